// File: rtl/fu_wb_buffer_if.sv
// Shared result type and squash interface used by fu_wb_buffer.
package fu_wb_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  id;
    logic [6:0]  prd;
    logic [31:0] rdval;
  } fu_output_t;
endpackage

interface squash_if;
  logic valid;
  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/fu_wb_buffer.sv
// fu_wb_buffer: captures one-cycle FU result pulses into a DEPTH-entry FIFO
// and replays them to the shared writeback port under valid/ready.
// Optional feature macro: FU_WB_BUFFER_BYPASS_EN (0-cycle path when empty).
module fu_wb_buffer
  import fu_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  fu_output_t       fuoutput_i,
  input  logic             fuoutput_i_valid,
  output logic             space_o,
  output fu_output_t       wb_o,
  output logic             wb_o_valid,
  input  logic             wb_i_ready,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  squash_if.slave          squash_io
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fu_output_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full, q_valid, byp, pop, push, drop;

  assign full    = (count == CNT_W'(DEPTH));
  assign q_valid = (count != '0) && !squash_io.valid;
  assign space_o = !full;
  assign count_o = count;

`ifdef FU_WB_BUFFER_BYPASS_EN
  // Empty buffer forwards the incoming result straight to writeback.
  assign byp = (count == '0) && fuoutput_i_valid && !squash_io.valid;
`else
  assign byp = 1'b0;
`endif

  assign wb_o_valid = q_valid || byp;
  assign wb_o       = byp ? fuoutput_i : mem[rd_ptr];

  // Queue-side handshakes; a bypassed result taken by writeback is never enqueued.
  assign pop  = q_valid && wb_i_ready;
  assign push = fuoutput_i_valid && !squash_io.valid && !(byp && wb_i_ready)
                && (!full || pop);
  assign drop = fuoutput_i_valid && !squash_io.valid && full && !pop;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy, pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      overflow_o <= 1'b0;
    end else if (squash_io.valid) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (drop) overflow_o <= 1'b1;
    end
  end

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fuoutput_i;
  end

  // A result arriving while full with no pop is lost; flag it in simulation.
  always_ff @(posedge clk) begin
    if (rstn) assert (!drop) else $warning("fu_wb_buffer: result dropped while full");
  end

endmodule

// File: tb/tb_fu_wb_buffer.sv
// Directed self-checking bench for fu_wb_buffer (DEPTH=2).
module tb_fu_wb_buffer;
  import fu_wb_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  fu_output_t fu_in;
  logic       fu_valid;
  logic       space;
  fu_output_t wb;
  logic       wb_valid;
  logic       wb_ready;
  logic [1:0] count;
  logic       ovf;
  int         checks = 0;
  int         errors = 0;

  squash_if sq ();

  fu_wb_buffer #(.DEPTH(2)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .fuoutput_i       (fu_in),
    .fuoutput_i_valid (fu_valid),
    .space_o          (space),
    .wb_o             (wb),
    .wb_o_valid       (wb_valid),
    .wb_i_ready       (wb_ready),
    .count_o          (count),
    .overflow_o       (ovf),
    .squash_io        (sq.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] id, input logic [31:0] val);
    fu_valid    = v;
    fu_in.pc    = 32'h1000 + {24'h0, id};
    fu_in.id    = id;
    fu_in.prd   = id[6:0];
    fu_in.rdval = val;
  endtask

  initial begin
    rstn = 1'b0; wb_ready = 1'b0; sq.valid = 1'b0;
    drive(1'b0, 8'd0, 32'h0);
    tick(); tick();
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_space", 64'(space), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rstn = 1'b1;

    // Single result
    drive(1'b1, 8'd5, 32'hDEAD); wb_ready = 1'b1;
`ifdef FU_WB_BUFFER_BYPASS_EN
    #1;
    chk("single_valid", 64'(wb_valid), 64'd1);
    chk("single_id", 64'(wb.id), 64'd5);
    chk("single_val", 64'(wb.rdval), 64'hDEAD);
    tick(); drive(1'b0, 8'd0, 32'h0); #1;
`else
    #1;
    chk("single_nocomb", 64'(wb_valid), 64'd0);
    tick(); drive(1'b0, 8'd0, 32'h0); #1;
    chk("single_valid", 64'(wb_valid), 64'd1);
    chk("single_id", 64'(wb.id), 64'd5);
    chk("single_val", 64'(wb.rdval), 64'hDEAD);
    chk("single_cnt1", 64'(count), 64'd1);
    tick();
`endif
    chk("single_cnt0", 64'(count), 64'd0);
    chk("single_empty", 64'(wb_valid), 64'd0);

    // Fill with ready low
    wb_ready = 1'b0;
    drive(1'b1, 8'd1, 32'h11); tick();
    drive(1'b1, 8'd2, 32'h22); tick();
    drive(1'b0, 8'd0, 32'h0); #1;
    chk("fill_space", 64'(space), 64'd0);
    chk("fill_count", 64'(count), 64'd2);
    chk("fill_head", 64'(wb.id), 64'd1);

    // Full + push + pop same cycle
    drive(1'b1, 8'd3, 32'h33); wb_ready = 1'b1; #1;
    chk("fpp_out", 64'(wb.id), 64'd1);
    tick(); drive(1'b0, 8'd0, 32'h0); wb_ready = 1'b0; #1;
    chk("fpp_count", 64'(count), 64'd2);
    chk("fpp_ovf", 64'(ovf), 64'd0);
    chk("fpp_head2", 64'(wb.id), 64'd2);
    wb_ready = 1'b1; tick();
    chk("fpp_head3", 64'(wb.id), 64'd3);
    chk("fpp_val3", 64'(wb.rdval), 64'h33);
    chk("fpp_cnt1", 64'(count), 64'd1);
    tick();
    chk("fpp_drain", 64'(wb_valid), 64'd0);

    // Overflow: full + push without pop
    wb_ready = 1'b0;
    drive(1'b1, 8'd10, 32'hA0); tick();
    drive(1'b1, 8'd11, 32'hB0); tick();
    drive(1'b1, 8'd4, 32'h44); tick();
    drive(1'b0, 8'd0, 32'h0); #1;
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("ovf_count", 64'(count), 64'd2);
    chk("ovf_head", 64'(wb.id), 64'd10);
    wb_ready = 1'b1; tick();
    chk("ovf_head2", 64'(wb.id), 64'd11);
    tick();
    chk("ovf_lost", 64'(wb_valid), 64'd0);
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // Squash with coincident push
    wb_ready = 1'b0;
    drive(1'b1, 8'd20, 32'h200); tick();
    drive(1'b1, 8'd21, 32'h210); tick();
    chk("sq_pre_cnt", 64'(count), 64'd2);
    drive(1'b1, 8'd7, 32'h77); sq.valid = 1'b1; wb_ready = 1'b1; #1;
    chk("sq_valid", 64'(wb_valid), 64'd0);
    tick(); sq.valid = 1'b0; drive(1'b0, 8'd0, 32'h0); wb_ready = 1'b0; #1;
    chk("sq_count", 64'(count), 64'd0);
    chk("sq_empty", 64'(wb_valid), 64'd0);
    chk("sq_ovf_kept", 64'(ovf), 64'd1);
    drive(1'b1, 8'd8, 32'h88); tick();
    drive(1'b0, 8'd0, 32'h0); #1;
    chk("sq_next_id", 64'(wb.id), 64'd8);
    chk("sq_next_cnt", 64'(count), 64'd1);

    // Reset clears sticky overflow
    rstn = 1'b0; tick(); rstn = 1'b1; #1;
    chk("rst2_ovf", 64'(ovf), 64'd0);
    chk("rst2_count", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
